// File: rtl/tcp_header_tx.sv
// tcp_header_tx: builds a TCP header, checksums it with the IPv4 pseudo-header and streams it
// big-endian in BYTES-wide beats. Define TCP_HDR_MSS_OPT_EN to append a 4-byte MSS option.
module tcp_header_tx #(
  parameter int unsigned BYTES     = 4,
  parameter logic [15:0] WIN_RESET = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               start_ready,
  input  logic [31:0]        ip_sa,
  input  logic [31:0]        ip_da,
  input  logic [15:0]        tcp_len,
  input  logic [15:0]        payload_csum,
  input  logic [15:0]        src_port,
  input  logic [15:0]        dst_port,
  input  logic [31:0]        seq_num,
  input  logic [31:0]        ack_num,
  input  logic [7:0]         flags,
  input  logic [15:0]        window,
  input  logic [15:0]        urg,
  input  logic [15:0]        mss,
  output logic [8*BYTES-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               err
);

`ifdef TCP_HDR_MSS_OPT_EN
  localparam int unsigned HDR_LEN = 24;
`else
  localparam int unsigned HDR_LEN = 20;
`endif
  localparam int unsigned HDR_W   = HDR_LEN * 8;
  localparam int unsigned BW      = 8 * BYTES;
  localparam int unsigned NBEATS  = HDR_LEN / BYTES;
  localparam int unsigned SUM_LEN = 6 + HDR_LEN / 2 + 1;
  localparam logic [3:0]  DOFF    = 4'(HDR_LEN / 4);

  if (!(BYTES == 1 || BYTES == 2 || BYTES == 4)) begin : g_bad_bytes
    $error("tcp_header_tx: BYTES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_SUM, S_EMIT} state_t;

  typedef struct packed {
    logic [31:0] sa;
    logic [31:0] da;
    logic [15:0] len;
    logic [15:0] pcsum;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] win;
    logic [15:0] urg;
  } fields_t;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   acc_q, acc_d;
  logic          err_q, err_d;
  fields_t       f_q, f_d;
  logic [15:0]   word;
  logic [HDR_W-1:0] hdr;
  logic [HDR_W-1:0] beat_sh;

`ifdef TCP_HDR_MSS_OPT_EN
  logic [15:0]   mss_q, mss_d;
`else
  logic          unused_mss;
  assign unused_mss = ^mss;
`endif

  // One's-complement add with end-around carry.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Word fed to the accumulator on each SUM cycle; the checksum slot contributes zero.
  always_comb begin
    word = 16'h0000;
    case (cnt_q)
      5'd0:  word = f_q.sa[31:16];
      5'd1:  word = f_q.sa[15:0];
      5'd2:  word = f_q.da[31:16];
      5'd3:  word = f_q.da[15:0];
      5'd4:  word = 16'h0006;
      5'd5:  word = f_q.len;
      5'd6:  word = f_q.sport;
      5'd7:  word = f_q.dport;
      5'd8:  word = f_q.seq[31:16];
      5'd9:  word = f_q.seq[15:0];
      5'd10: word = f_q.ack[31:16];
      5'd11: word = f_q.ack[15:0];
      5'd12: word = {DOFF, 4'h0, f_q.flags};
      5'd13: word = f_q.win;
      5'd15: word = f_q.urg;
`ifdef TCP_HDR_MSS_OPT_EN
      5'd16: word = 16'h0204;
      5'd17: word = mss_q;
      5'd18: word = f_q.pcsum;
`else
      5'd16: word = f_q.pcsum;
`endif
      default: word = 16'h0000;
    endcase
  end

  always_comb begin
    hdr = {f_q.sport, f_q.dport, f_q.seq, f_q.ack, DOFF, 4'h0, f_q.flags, f_q.win, ~acc_q, f_q.urg
`ifdef TCP_HDR_MSS_OPT_EN
           , 8'h02, 8'h04, mss_q
`endif
          };
    beat_sh = hdr << (cnt_q * BW);
  end

  assign start_ready = (state_q == S_IDLE) && !rst;
  assign m_valid     = (state_q == S_EMIT);
  assign m_last      = m_valid && (cnt_q == 5'(NBEATS - 1));
  assign m_data      = m_valid ? beat_sh[HDR_W-1 -: BW] : '0;
  assign err         = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    f_d     = f_q;
    err_d   = 1'b0;
`ifdef TCP_HDR_MSS_OPT_EN
    mss_d   = mss_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && start_ready) begin
          if (tcp_len < 16'(HDR_LEN)) begin
            err_d = 1'b1;
          end else begin
            f_d = '{sa: ip_sa, da: ip_da, len: tcp_len, pcsum: payload_csum,
                    sport: src_port, dport: dst_port, seq: seq_num, ack: ack_num,
                    flags: flags, win: window, urg: urg};
`ifdef TCP_HDR_MSS_OPT_EN
            mss_d = mss;
`endif
            acc_d   = 16'h0000;
            cnt_d   = 5'd0;
            state_d = S_SUM;
          end
        end
      end
      // The extra cycle after the last word lets ~acc settle before the first beat.
      S_SUM: begin
        if (cnt_q == 5'(SUM_LEN)) begin
          cnt_d   = 5'd0;
          state_d = S_EMIT;
        end else begin
          acc_d = ones_add(acc_q, word);
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          if (cnt_q == 5'(NBEATS - 1)) begin
            cnt_d   = 5'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 16'h0000;
      err_q   <= 1'b0;
      f_q     <= '0;
      f_q.win <= WIN_RESET;
`ifdef TCP_HDR_MSS_OPT_EN
      mss_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      f_q     <= f_d;
`ifdef TCP_HDR_MSS_OPT_EN
      mss_q   <= mss_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcp_header_tx.sv
// Bench for tcp_header_tx: a 4-byte and a 1-byte instance share one request bus; headers
// accepted on each output are collected and compared with a byte-level reference model.
module tb_tcp_header_tx;

`ifdef TCP_HDR_MSS_OPT_EN
  localparam int HDR_LEN = 24;
  localparam int SUM_CYC = 19;
  localparam logic [15:0] CSUM1 = 16'h71A0;
`else
  localparam int HDR_LEN = 20;
  localparam int SUM_CYC = 17;
  localparam logic [15:0] CSUM1 = 16'h895C;
`endif
  localparam int HDR_BITS = HDR_LEN * 8;

  typedef struct {
    logic [31:0] sa, da;
    logic [15:0] len, pcsum, sport, dport;
    logic [31:0] seq, ack;
    logic [7:0]  flags;
    logic [15:0] win, urg, mss;
  } req_t;

  typedef struct {
    req_t        r;
    bit          exp_err;
    bit          chk_csum;
    logic [15:0] exp_csum;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] ip_sa = '0, ip_da = '0, seq_num = '0, ack_num = '0;
  logic [15:0] tcp_len = '0, payload_csum = '0, src_port = '0, dst_port = '0;
  logic [15:0] window = '0, urg = '0, mss = '0;
  logic [7:0]  flags = '0;
  logic m_ready4 = 1'b1, m_ready1 = 1'b1;
  logic start_ready4, start_ready1, m_valid4, m_valid1, m_last4, m_last1, err4, err1;
  logic [31:0] m_data4;
  logic [7:0]  m_data1;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;
  int stab_err4 = 0, stab_err1 = 0;
  logic [7:0] q4[$], q1[$];
  bit         l4[$], l1[$];

  always #5 clk = ~clk;

  tcp_header_tx #(.BYTES(4), .WIN_RESET(16'hFFFF)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready4),
    .ip_sa(ip_sa), .ip_da(ip_da), .tcp_len(tcp_len), .payload_csum(payload_csum),
    .src_port(src_port), .dst_port(dst_port), .seq_num(seq_num), .ack_num(ack_num),
    .flags(flags), .window(window), .urg(urg), .mss(mss),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready4), .m_last(m_last4), .err(err4));

  tcp_header_tx #(.BYTES(1), .WIN_RESET(16'hFFFF)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready1),
    .ip_sa(ip_sa), .ip_da(ip_da), .tcp_len(tcp_len), .payload_csum(payload_csum),
    .src_port(src_port), .dst_port(dst_port), .seq_num(seq_num), .ack_num(ack_num),
    .flags(flags), .window(window), .urg(urg), .mss(mss),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1), .err(err1));

  // Sink ready: always, the 1,0,0 pattern, or random per instance.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: begin m_ready4 = 1'b1; m_ready1 = 1'b1; end
        1: begin m_ready4 = (ph % 3 == 0); m_ready1 = (ph % 3 == 0); end
        default: begin m_ready4 = 1'($urandom % 2); m_ready1 = 1'($urandom % 2); end
      endcase
      ph++;
    end
  end

  // Collect accepted beats; flag any change or withdrawal of a stalled beat.
  initial begin
    bit stall4 = 0, stall1 = 0;
    logic [32:0] held4 = '0;
    logic [8:0]  held1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall4 = 0; stall1 = 0;
      end else begin
        if (m_valid4) begin
          if (stall4 && ({m_data4, m_last4} !== held4)) stab_err4++;
          if (m_ready4) begin
            for (int k = 3; k >= 0; k--) q4.push_back(m_data4[k*8 +: 8]);
            l4.push_back(m_last4);
            stall4 = 0;
          end else begin
            stall4 = 1; held4 = {m_data4, m_last4};
          end
        end else begin
          if (stall4) stab_err4++;
          stall4 = 0;
        end
        if (m_valid1) begin
          if (stall1 && ({m_data1, m_last1} !== held1)) stab_err1++;
          if (m_ready1) begin
            q1.push_back(m_data1);
            l1.push_back(m_last1);
            stall1 = 0;
          end else begin
            stall1 = 1; held1 = {m_data1, m_last1};
          end
        end else begin
          if (stall1) stab_err1++;
          stall1 = 0;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Header bytes from the field list; checksum = ~(folded sum of pseudo-header, header, payload).
  function automatic logic [HDR_BITS-1:0] model_hdr(input req_t r);
    logic [HDR_BITS-1:0] h;
    logic [95:0] ph;
    logic [31:0] s;
    h = {r.sport, r.dport, r.seq, r.ack, 8'((HDR_LEN / 4) * 16), r.flags, r.win, 16'h0000, r.urg
`ifdef TCP_HDR_MSS_OPT_EN
         , 8'h02, 8'h04, r.mss
`endif
        };
    ph = {r.sa, r.da, 16'h0006, r.len};
    s = {16'h0, r.pcsum};
    for (int i = 0; i < 6; i++) s += {16'h0, ph[i*16 +: 16]};
    for (int i = 0; i < HDR_LEN / 2; i++) s += {16'h0, h[i*16 +: 16]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    h[HDR_BITS-1-128 -: 16] = ~s[15:0];
    return h;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.sa = $urandom; r.da = $urandom; r.seq = $urandom; r.ack = $urandom;
    r.len = 16'($urandom_range(HDR_LEN, 1500)); r.pcsum = 16'($urandom);
    r.sport = 16'($urandom); r.dport = 16'($urandom); r.flags = 8'($urandom);
    r.win = 16'($urandom); r.urg = 16'($urandom); r.mss = 16'($urandom);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input req_t r);
    ip_sa = r.sa; ip_da = r.da; tcp_len = r.len; payload_csum = r.pcsum;
    src_port = r.sport; dst_port = r.dport; seq_num = r.seq; ack_num = r.ack;
    flags = r.flags; window = r.win; urg = r.urg; mss = r.mss;
  endtask

  task automatic send(input req_t r);
    @(posedge clk); #1;
    drive(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (!(start_ready4 && start_ready1) && c < 2000) begin @(posedge clk); #1; c++; end
    if (c >= 2000) chk({nm, " idle timeout"}, {start_ready4, start_ready1}, 2'b11);
  endtask

  task automatic wait_bytes(input string nm, input int n4, input int n1, output bit ok);
    int c = 0;
    while ((q4.size() < n4 || q1.size() < n1) && c < 3000) begin @(posedge clk); #1; c++; end
    ok = (c < 3000);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s bytes timeout: got %0d/%0d expected %0d/%0d", nm, q4.size(), q1.size(), n4, n1);
    end
  endtask

  task automatic cmp_hdr(input string nm, input int inst, input int base, input req_t r);
    logic [HDR_BITS-1:0] h;
    int nb;
    h = model_hdr(r);
    nb = (inst == 4) ? HDR_LEN / 4 : HDR_LEN;
    for (int i = 0; i < HDR_LEN; i++)
      chk($sformatf("%s x%0d byte%0d", nm, inst, i),
          64'((inst == 4) ? q4[base + i] : q1[base + i]), 64'(h[HDR_BITS-1-8*i -: 8]));
    for (int j = 0; j < nb; j++)
      chk($sformatf("%s x%0d last%0d", nm, inst, j),
          64'((inst == 4) ? l4[base / 4 + j] : l1[base + j]), 64'(j == nb - 1));
  endtask

  task automatic do_hdr(input string nm, input req_t r, input bit exp_err, input bit chk_csum,
                        input logic [15:0] exp_csum);
    int b4, b1, k;
    bit anyv, anynr, anyerr, ok;
    wait_idle(nm);
    b4 = q4.size(); b1 = q1.size();
    send(r);
    chk({nm, " err"}, {err4, err1}, {exp_err, exp_err});
    if (exp_err) begin
      anyv = 0; anynr = 0; anyerr = 0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk); #1;
        if (m_valid4 || m_valid1) anyv = 1;
        if (!start_ready4 || !start_ready1) anynr = 1;
        if (err4 || err1) anyerr = 1;
      end
      chk({nm, " err one cycle"}, anyerr, 0);
      chk({nm, " no valid"}, anyv, 0);
      chk({nm, " ready held"}, anynr, 0);
      chk({nm, " nothing emitted"}, q4.size() + q1.size(), b4 + b1);
    end else begin
      k = 0;
      while (!(m_valid4 && m_valid1) && k < 200) begin @(posedge clk); #1; k++; end
      chk({nm, " latency"}, k, SUM_CYC + 1);
      wait_bytes(nm, b4 + HDR_LEN, b1 + HDR_LEN, ok);
      if (ok) begin
        cmp_hdr(nm, 4, b4, r);
        cmp_hdr(nm, 1, b1, r);
        if (chk_csum) chk({nm, " csum"}, {q4[b4 + 16], q4[b4 + 17]}, exp_csum);
      end
    end
  endtask

  initial begin
    vec_t tbl[6];
    req_t t1, t, ta, tb2;
    logic [HDR_BITS-1:0] h;
    int b4, b1, c;
    bit ok, found;

    t1.sa = 32'h0A000001; t1.da = 32'h0A000002; t1.len = 16'(HDR_LEN); t1.pcsum = 16'h0;
    t1.sport = 16'h1234; t1.dport = 16'h0050; t1.seq = 32'h0; t1.ack = 32'h0;
    t1.flags = 8'h02; t1.win = 16'hFFFF; t1.urg = 16'h0; t1.mss = 16'h05B4;

    tbl[0] = '{r: t1, exp_err: 1'b0, chk_csum: 1'b1, exp_csum: CSUM1};
    t = t1; t.len = 16'd12;
    tbl[1] = '{r: t, exp_err: 1'b1, chk_csum: 1'b0, exp_csum: 16'h0};
    t = t1; t.len = 16'(HDR_LEN - 1);
    tbl[2] = '{r: t, exp_err: 1'b1, chk_csum: 1'b0, exp_csum: 16'h0};
    t = t1; t.flags = 8'h18; t.seq = 32'h01020304; t.pcsum = 16'h0;
    h = model_hdr(t);
    t.pcsum = h[HDR_BITS-1-128 -: 16];
    tbl[3] = '{r: t, exp_err: 1'b0, chk_csum: 1'b1, exp_csum: 16'h0000};
    t.sa = 32'hC0A80101; t.da = 32'h08080808; t.len = 16'd1000; t.pcsum = 16'hABCD;
    t.sport = 16'hC350; t.dport = 16'h01BB; t.seq = 32'hDEADBEEF; t.ack = 32'h12345678;
    t.flags = 8'h10; t.win = 16'h2000; t.urg = 16'h0; t.mss = 16'h0218;
    tbl[4] = '{r: t, exp_err: 1'b0, chk_csum: 1'b0, exp_csum: 16'h0};
    t.sa = '1; t.da = '1; t.len = 16'hFFFF; t.pcsum = '1; t.sport = '1; t.dport = '1;
    t.seq = '1; t.ack = '1; t.flags = '1; t.win = '1; t.urg = '1; t.mss = '1;
    tbl[5] = '{r: t, exp_err: 1'b0, chk_csum: 1'b0, exp_csum: 16'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst start_ready", {start_ready4, start_ready1}, 2'b00);
    chk("rst m_valid", {m_valid4, m_valid1}, 2'b00);
    chk("rst m_last", {m_last4, m_last1}, 2'b00);
    chk("rst err", {err4, err1}, 2'b00);
    chk("rst m_data", {m_data4, m_data1}, 40'h0);
    rst = 1'b0;
    #1;
    chk("post rst start_ready", {start_ready4, start_ready1}, 2'b11);

    for (int i = 0; i < 6; i++)
      do_hdr($sformatf("vec%0d", i), tbl[i].r, tbl[i].exp_err, tbl[i].chk_csum, tbl[i].exp_csum);

    // Stalling sink 1,0,0,...
    rdy_mode = 1;
    do_hdr("stall pattern", t1, 1'b0, 1'b1, CSUM1);
    rdy_mode = 0;

    // Reset during the third beat of the 4-byte instance, then a clean header
    wait_idle("rst emit");
    send(t1);
    c = 0;
    while (!m_valid4 && c < 200) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst mid emit valid", {m_valid4, m_valid1}, 2'b00);
    rst = 1'b0;
    #1;
    chk("rst mid emit ready", {start_ready4, start_ready1}, 2'b11);
    do_hdr("after rst", t1, 1'b0, 1'b1, CSUM1);

    // Inputs change and start stays high while busy: one header of the latched values
    wait_idle("hold start");
    b4 = q4.size(); b1 = q1.size();
    ta = rand_req();
    @(posedge clk); #1;
    drive(ta);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; drive(rand_req()); end
    start = 1'b0;
    wait_bytes("hold start", b4 + HDR_LEN, b1 + HDR_LEN, ok);
    repeat (40) @(posedge clk);
    #1;
    chk("hold start one hdr x4", q4.size(), b4 + HDR_LEN);
    chk("hold start one hdr x1", q1.size(), b1 + HDR_LEN);
    if (ok) begin cmp_hdr("hold start", 4, b4, ta); cmp_hdr("hold start", 1, b1, ta); end

    // Back-to-back request on the cycle after the final beat of the 4-byte instance
    wait_idle("b2b");
    b4 = q4.size(); b1 = q1.size();
    ta = rand_req(); tb2 = rand_req();
    send(ta);
    found = 0; c = 0;
    while (!found && c < 200) begin
      @(negedge clk);
      if (m_valid4 && m_last4 && m_ready4) found = 1;
      c++;
    end
    chk("b2b last seen", found, 1);
    @(posedge clk); #1;
    chk("b2b ready x4", start_ready4, 1);
    chk("b2b busy x1", start_ready1, 0);
    drive(tb2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accepted", start_ready4, 0);
    wait_bytes("b2b", b4 + 2 * HDR_LEN, b1 + HDR_LEN, ok);
    wait_idle("b2b end");
    repeat (10) @(posedge clk);
    #1;
    chk("b2b x1 ignored", q1.size(), b1 + HDR_LEN);
    if (ok) begin
      cmp_hdr("b2b first", 4, b4, ta);
      cmp_hdr("b2b second", 4, b4 + HDR_LEN, tb2);
      cmp_hdr("b2b x1", 1, b1, ta);
    end

    // Randomised requests and sink behaviour
    for (int i = 0; i < 24; i++) begin
      rdy_mode = $urandom_range(0, 2);
      t = rand_req();
      if ($urandom_range(0, 4) == 0) t.len = 16'($urandom_range(0, HDR_LEN - 1));
      do_hdr($sformatf("rand%0d", i), t, t.len < 16'(HDR_LEN), 1'b0, 16'h0);
    end
    rdy_mode = 0;

    chk("stall stable x4", stab_err4, 0);
    chk("stall stable x1", stab_err1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
